// File: rtl/rgb2gray_stream.sv
// Streaming RGB-to-gray converter: two-stage pipeline with valid/ready flow control,
// run-time mode select (average, luma, max, min) and frame sidebands kept in step with each pixel.
module rgb2gray_stream #(
    parameter int DATA_W  = 8,
    parameter int LUMA_WR = 77,
    parameter int LUMA_WG = 150,
    parameter int LUMA_WB = 29
) (
    input  logic              Clk_i,
    input  logic              Reset_ni,
    input  logic              Valid_i,
    output logic              Ready_o,
    input  logic [DATA_W-1:0] RedColor_i,
    input  logic [DATA_W-1:0] GreenColor_i,
    input  logic [DATA_W-1:0] BlueColor_i,
    input  logic [1:0]        Mode_i,
    input  logic              Sof_i,
    input  logic              Eol_i,
    output logic              Valid_o,
    input  logic              Ready_i,
    output logic [DATA_W-1:0] GrayColor_o,
    output logic              Sof_o,
    output logic              Eol_o,
    output logic [31:0]       PixelCount_o
);

    localparam int SUM_W  = DATA_W + 2;
    localparam int LUMA_W = DATA_W + 9;

    typedef enum logic [1:0] {
        MODE_AVG  = 2'd0,
        MODE_LUMA = 2'd1,
        MODE_MAX  = 2'd2,
        MODE_MIN  = 2'd3
    } mode_t;

    logic              en;
    logic              accept;

    logic [DATA_W-1:0] maxRgb;
    logic [DATA_W-1:0] minRgb;
    logic [SUM_W-1:0]  inSum;
    logic [LUMA_W-1:0] inLuma;

    logic              s1Valid;
    logic [SUM_W-1:0]  s1Sum;
    logic [LUMA_W-1:0] s1Luma;
    logic [DATA_W-1:0] s1Max;
    logic [DATA_W-1:0] s1Min;
    mode_t             s1Mode;
    logic              s1Sof;
    logic              s1Eol;

    logic [SUM_W-1:0]  avgFull;
    logic [LUMA_W-1:0] lumaFull;
    logic [DATA_W-1:0] grayNext;

    // The whole pipeline advances together unless a held output is still waiting for downstream.
    assign en      = !Valid_o || Ready_i;
    assign Ready_o = en;
    assign accept  = Valid_i && en;

    always_comb begin
        maxRgb = RedColor_i;
        minRgb = RedColor_i;
        if (GreenColor_i > maxRgb) maxRgb = GreenColor_i;
        if (BlueColor_i  > maxRgb) maxRgb = BlueColor_i;
        if (GreenColor_i < minRgb) minRgb = GreenColor_i;
        if (BlueColor_i  < minRgb) minRgb = BlueColor_i;
    end

    assign inSum  = SUM_W'(RedColor_i) + SUM_W'(GreenColor_i) + SUM_W'(BlueColor_i);
    assign inLuma = LUMA_W'(LUMA_WR) * LUMA_W'(RedColor_i)
                  + LUMA_W'(LUMA_WG) * LUMA_W'(GreenColor_i)
                  + LUMA_W'(LUMA_WB) * LUMA_W'(BlueColor_i)
                  + LUMA_W'(128);

    // Stage 1 captures every candidate result so stage 2 is only a divide and a mux.
    always_ff @(posedge Clk_i or negedge Reset_ni) begin
        if (!Reset_ni) begin
            s1Valid <= 1'b0;
            s1Sum   <= '0;
            s1Luma  <= '0;
            s1Max   <= '0;
            s1Min   <= '0;
            s1Mode  <= MODE_AVG;
            s1Sof   <= 1'b0;
            s1Eol   <= 1'b0;
        end else if (en) begin
            s1Valid <= accept;
            if (accept) begin
                s1Sum  <= inSum;
                s1Luma <= inLuma;
                s1Max  <= maxRgb;
                s1Min  <= minRgb;
                s1Mode <= mode_t'(Mode_i);
                s1Sof  <= Sof_i;
                s1Eol  <= Eol_i;
            end
        end
    end

    // Division by a constant 3 stays exact; the shift-and-add approximation is off by one on some sums.
    assign avgFull  = s1Sum / SUM_W'(3);
    assign lumaFull = s1Luma >> 8;

    always_comb begin
        grayNext = '0;
        case (s1Mode)
            MODE_AVG:  grayNext = avgFull[DATA_W-1:0];
            MODE_LUMA: grayNext = lumaFull[DATA_W-1:0];
            MODE_MAX:  grayNext = s1Max;
            MODE_MIN:  grayNext = s1Min;
            default:   grayNext = '0;
        endcase
    end

    always_ff @(posedge Clk_i or negedge Reset_ni) begin
        if (!Reset_ni) begin
            Valid_o     <= 1'b0;
            GrayColor_o <= '0;
            Sof_o       <= 1'b0;
            Eol_o       <= 1'b0;
        end else if (en) begin
            Valid_o <= s1Valid;
            if (s1Valid) begin
                GrayColor_o <= grayNext;
                Sof_o       <= s1Sof;
                Eol_o       <= s1Eol;
            end
        end
    end

    // Counts delivered pixels; a start-of-frame pixel restarts the count at one.
    always_ff @(posedge Clk_i or negedge Reset_ni) begin
        if (!Reset_ni) begin
            PixelCount_o <= '0;
        end else if (Valid_o && Ready_i) begin
            if (Sof_o) PixelCount_o <= 32'd1;
            else       PixelCount_o <= PixelCount_o + 32'd1;
        end
    end

    lumaRange : assert property (@(posedge Clk_i) disable iff (!Reset_ni)
        (s1Valid && s1Mode == MODE_LUMA) |-> (lumaFull[LUMA_W-1:DATA_W] == '0));

    avgRange : assert property (@(posedge Clk_i) disable iff (!Reset_ni)
        (s1Valid && s1Mode == MODE_AVG) |-> (avgFull[SUM_W-1:DATA_W] == '0));

endmodule

// File: tb/tb_rgb2gray_stream.sv
// Scoreboard bench for rgb2gray_stream: stimulus pushes expected pixels, a negedge monitor
// pops and compares every output handshake, plus directed latency, stall and reset checks.
module tb_rgb2gray_stream;

    typedef struct {
        int gray;
        bit sof;
        bit eol;
        int count;
    } ExpEntry;

    logic        Clk_i = 1'b0;
    logic        Reset_ni = 1'b0;
    logic        Valid_i = 1'b0;
    logic        Ready_o;
    logic [7:0]  RedColor_i = '0;
    logic [7:0]  GreenColor_i = '0;
    logic [7:0]  BlueColor_i = '0;
    logic [1:0]  Mode_i = '0;
    logic        Sof_i = 1'b0;
    logic        Eol_i = 1'b0;
    logic        Valid_o;
    logic        Ready_i = 1'b1;
    logic [7:0]  GrayColor_o;
    logic        Sof_o;
    logic        Eol_o;
    logic [31:0] PixelCount_o;

    ExpEntry expQ[$];
    int      testsRun = 0;
    int      failures = 0;
    int      modelCount = 0;

    bit      countPending = 0;
    int      pendingCount = 0;
    bit      prevStalled = 0;
    int      prevGray = 0;
    bit      prevSof = 0;
    bit      prevEol = 0;

    rgb2gray_stream #(
        .DATA_W (8),
        .LUMA_WR(77),
        .LUMA_WG(150),
        .LUMA_WB(29)
    ) dut (
        .Clk_i       (Clk_i),
        .Reset_ni    (Reset_ni),
        .Valid_i     (Valid_i),
        .Ready_o     (Ready_o),
        .RedColor_i  (RedColor_i),
        .GreenColor_i(GreenColor_i),
        .BlueColor_i (BlueColor_i),
        .Mode_i      (Mode_i),
        .Sof_i       (Sof_i),
        .Eol_i       (Eol_i),
        .Valid_o     (Valid_o),
        .Ready_i     (Ready_i),
        .GrayColor_o (GrayColor_o),
        .Sof_o       (Sof_o),
        .Eol_o       (Eol_o),
        .PixelCount_o(PixelCount_o)
    );

    always #5 Clk_i = ~Clk_i;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        testsRun++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one pixel from posedge+1 and holds it until accepted; the expectation is queued on accept.
    task automatic applyStimulus(input int r, input int g, input int b, input int mode,
                                 input bit sof, input bit eol, input int expGray);
        bit      accepted;
        ExpEntry e;
        Valid_i      = 1'b1;
        RedColor_i   = 8'(r);
        GreenColor_i = 8'(g);
        BlueColor_i  = 8'(b);
        Mode_i       = 2'(mode);
        Sof_i        = sof;
        Eol_i        = eol;
        accepted     = 0;
        for (int t = 0; t < 100 && !accepted; t++) begin
            @(negedge Clk_i);
            accepted = Ready_o;
            @(posedge Clk_i);
        end
        if (!accepted) begin
            checkOutput("acceptTimeout", 0, 1);
        end else begin
            modelCount = sof ? 1 : modelCount + 1;
            e.gray  = expGray;
            e.sof   = sof;
            e.eol   = eol;
            e.count = modelCount;
            expQ.push_back(e);
        end
        #1;
        Valid_i = 1'b0;
        Sof_i   = 1'b0;
        Eol_i   = 1'b0;
    endtask

    task automatic applyReset();
        @(posedge Clk_i);
        #1;
        Reset_ni   = 1'b0;
        expQ.delete();
        modelCount = 0;
        repeat (2) @(posedge Clk_i);
        #1;
        Reset_ni = 1'b1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge Clk_i);
        #1;
    endtask

    // Monitor: pops on each handshake, checks the counter a cycle later and output stability while stalled.
    always @(negedge Clk_i) begin
        ExpEntry e;
        if (!Reset_ni) begin
            countPending = 0;
            prevStalled  = 0;
        end else begin
            if (countPending) begin
                checkOutput("pixelCount", PixelCount_o, pendingCount);
                countPending = 0;
            end
            if (prevStalled) begin
                checkOutput("stallGray", GrayColor_o, prevGray);
                checkOutput("stallSof", Sof_o, prevSof);
                checkOutput("stallEol", Eol_o, prevEol);
            end
            if (Valid_o && Ready_i) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedOutput", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("gray", GrayColor_o, e.gray);
                    checkOutput("sof", Sof_o, e.sof);
                    checkOutput("eol", Eol_o, e.eol);
                    countPending = 1;
                    pendingCount = e.count;
                end
            end
            prevStalled = Valid_o && !Ready_i;
            prevGray    = GrayColor_o;
            prevSof     = Sof_o;
            prevEol     = Eol_o;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r, g, b, s;
        Ready_i = 1'b1;
        #3;
        checkOutput("resetValid", Valid_o, 0);
        checkOutput("resetGray", GrayColor_o, 0);
        checkOutput("resetCount", PixelCount_o, 0);
        checkOutput("resetSof", Sof_o, 0);
        applyReset();
        checkOutput("readyAfterReset", Ready_o, 1);

        // Latency: accepted at one edge, visible after the next edge, gone after the one after that.
        applyStimulus(200, 100, 50, 0, 0, 0, 116);
        @(negedge Clk_i);
        checkOutput("latencyStage1", Valid_o, 0);
        @(negedge Clk_i);
        checkOutput("latencyValid", Valid_o, 1);
        checkOutput("latencyGray", GrayColor_o, 116);
        @(negedge Clk_i);
        checkOutput("latencyBubble", Valid_o, 0);
        @(posedge Clk_i);
        #1;

        applyStimulus(255, 0, 0, 0, 0, 0, 85);
        applyStimulus(255, 0, 0, 1, 0, 0, 77);
        applyStimulus(255, 0, 0, 2, 0, 0, 255);
        applyStimulus(255, 0, 0, 3, 0, 0, 0);
        applyStimulus(255, 255, 255, 1, 0, 0, 255);
        applyStimulus(200, 100, 50, 1, 0, 0, 124);
        applyStimulus(200, 100, 50, 2, 0, 0, 200);
        applyStimulus(200, 100, 50, 3, 0, 0, 50);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);

        // Every reachable channel sum in average mode.
        for (int i = 0; i <= 765; i++) begin
            s = i;
            r = (s > 255) ? 255 : s;
            s = s - r;
            g = (s > 255) ? 255 : s;
            b = s - g;
            applyStimulus(r, g, b, 0, 0, 0, i / 3);
        end
        waitCycles(4);

        fork
            begin
                for (int i = 0; i < 10; i++) applyStimulus(i * 20 + 3, 250, 251, 3, 0, 0, i * 20 + 3);
            end
            begin
                repeat (4) @(posedge Clk_i);
                #1;
                Ready_i = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge Clk_i);
                    checkOutput("readyDrop", Ready_o, 0);
                end
                @(posedge Clk_i);
                #1;
                Ready_i = 1'b1;
            end
        join
        waitCycles(4);

        for (int i = 0; i < 12; i++)
            applyStimulus(i * 10 + 5, 0, 0, 2, i == 0, (i % 4) == 3, i * 10 + 5);
        applyStimulus(7, 9, 8, 2, 1, 0, 9);
        applyStimulus(7, 9, 8, 3, 0, 1, 7);
        applyStimulus(30, 60, 90, 0, 1, 1, 60);
        waitCycles(6);
        checkOutput("drainEmpty", expQ.size(), 0);

        // Two pixels stuck in the pipe, then reset without any clock edge.
        Ready_i = 1'b0;
        applyStimulus(11, 22, 33, 0, 0, 0, 22);
        applyStimulus(44, 55, 66, 0, 0, 0, 55);
        checkOutput("inFlightValid", Valid_o, 1);
        #1;
        Reset_ni   = 1'b0;
        expQ.delete();
        modelCount = 0;
        #1;
        checkOutput("asyncResetValid", Valid_o, 0);
        checkOutput("asyncResetCount", PixelCount_o, 0);
        repeat (2) @(posedge Clk_i);
        #1;
        Reset_ni = 1'b1;
        Ready_i  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk_i);
            checkOutput("noStaleOutput", Valid_o, 0);
        end
        @(posedge Clk_i);
        #1;
        applyStimulus(90, 90, 90, 0, 1, 0, 90);
        waitCycles(5);
        checkOutput("finalDrain", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
